logic_serial_ctrl: RTL and testbench

Multi-cycle controller that drives the team's existing 1-bit logic slice. It accepts a WIDTH-bit logic operation through a valid/ready request, feeds operand bits LSB-first with the 2-bit control code, and collects the slice output into a result shift register. It returns the WIDTH-bit result through a valid/ready response. It sits between the datapath issue logic and a single shared 1-bit logic slice.

---
 rtl/logic_serial_ctrl.sv | 92 +++++++++
 tb/tb_logic_serial_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_serial_ctrl.sv
// Bit-serial controller for a shared 1-bit logic slice: shifts operands out LSB-first,
// collects the slice output into a result register and hands it back via valid/ready.
module logic_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             lu_a,
    output logic             lu_b,
    output logic [1:0]       lu_control,
    input  logic             lu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] result_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            op_reg     <= 2'b00;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        a_sh_reg  <= req_a;
                        b_sh_reg  <= req_b;
                        op_reg    <= req_op;
                        count_reg <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Slice output arrives MSB-side so bit 0 lands in result[0] after WIDTH shifts.
                    result_reg <= {lu_out, result_reg[WIDTH-1:1]};
                    a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
                    b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
                    if (count_reg == LAST) begin
                        count_reg <= '0;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Slice inputs are forced quiet outside RUN so the shared slice sees no stray activity.
    assign lu_a       = (state_reg == RUN) ? a_sh_reg[0] : 1'b0;
    assign lu_b       = (state_reg == RUN) ? b_sh_reg[0] : 1'b0;
    assign lu_control = (state_reg == RUN) ? op_reg : 2'b00;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign resp_data  = result_reg;
    assign resp_zero  = ~|result_reg;

endmodule

// File: tb/tb_logic_serial_ctrl.sv
// Directed bench for logic_serial_ctrl at WIDTH=8 and WIDTH=32, each wired to a
// behavioural 1-bit logic slice.
module tb_logic_serial_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // WIDTH=8 instance
    logic       req_valid8 = 0, req_ready8, resp_valid8, resp_ready8 = 0, resp_zero8, busy8;
    logic [1:0] req_op8 = 0, lu_control8;
    logic [7:0] req_a8 = 0, req_b8 = 0, resp_data8;
    logic       lu_a8, lu_b8, lu_out8;

    // WIDTH=32 instance
    logic        req_valid32 = 0, req_ready32, resp_valid32, resp_ready32 = 0, resp_zero32, busy32;
    logic [1:0]  req_op32 = 0, lu_control32;
    logic [31:0] req_a32 = 0, req_b32 = 0, resp_data32;
    logic        lu_a32, lu_b32, lu_out32;

    logic_serial_ctrl #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid8), .req_ready(req_ready8), .req_op(req_op8),
        .req_a(req_a8), .req_b(req_b8),
        .lu_a(lu_a8), .lu_b(lu_b8), .lu_control(lu_control8), .lu_out(lu_out8),
        .resp_valid(resp_valid8), .resp_ready(resp_ready8), .resp_data(resp_data8),
        .resp_zero(resp_zero8), .busy(busy8)
    );

    logic_serial_ctrl #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid32), .req_ready(req_ready32), .req_op(req_op32),
        .req_a(req_a32), .req_b(req_b32),
        .lu_a(lu_a32), .lu_b(lu_b32), .lu_control(lu_control32), .lu_out(lu_out32),
        .resp_valid(resp_valid32), .resp_ready(resp_ready32), .resp_data(resp_data32),
        .resp_zero(resp_zero32), .busy(busy32)
    );

    // Behavioural stand-in for the 1-bit logic slice.
    always_comb begin
        lu_out8 = 1'b0;
        case (lu_control8)
            2'b00: lu_out8 = lu_a8 & lu_b8;
            2'b01: lu_out8 = lu_a8 | lu_b8;
            2'b10: lu_out8 = ~(lu_a8 | lu_b8);
            default: lu_out8 = lu_a8 ^ lu_b8;
        endcase
    end

    always_comb begin
        lu_out32 = 1'b0;
        case (lu_control32)
            2'b00: lu_out32 = lu_a32 & lu_b32;
            2'b01: lu_out32 = lu_a32 | lu_b32;
            2'b10: lu_out32 = ~(lu_a32 | lu_b32);
            default: lu_out32 = lu_a32 ^ lu_b32;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        tests_run++;
        if (req_ready8 !== 1'b1 || resp_valid8 !== 1'b0 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake: ready=%b valid=%b busy=%b, required 1 0 0",
                     req_ready8, resp_valid8, busy8);
        end
        tests_run++;
        if (lu_control8 !== 2'b00 || resp_zero8 !== 1'b1 || resp_data8 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: lu_control=%b zero=%b data=%h, required 00 1 00",
                     lu_control8, resp_zero8, resp_data8);
        end
        $display("[TB] reset released, ready=%b busy=%b", req_ready8, busy8);
    endtask

    // Issue one WIDTH=8 operation, check latency, slice drive, data and zero flag, then handshake.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input logic [7:0] exp, input string name);
        int lat;
        lat = 0;
        while (req_ready8 !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        req_a8 = a; req_b8 = b; req_op8 = op; req_valid8 = 1'b1;
        step();
        req_valid8 = 1'b0;
        tests_run++;
        if (lu_control8 !== op || busy8 !== 1'b1 || req_ready8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_run_drive: lu_control=%b busy=%b ready=%b, required %b 1 0",
                     name, lu_control8, busy8, req_ready8, op);
        end
        lat = 0;
        while (resp_valid8 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != 8) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d edges, required 8", name, lat);
        end
        tests_run++;
        if (resp_data8 !== exp || resp_zero8 !== (exp == 8'h00)) begin
            tests_failed++;
            $display("FAIL %s_data: data=%h zero=%b, required %h %b",
                     name, resp_data8, resp_zero8, exp, (exp == 8'h00));
        end
        $display("[TB] %s a=%h b=%h op=%b -> %h (zero=%b)", name, a, b, op, resp_data8, resp_zero8);
        resp_ready8 = 1'b1;
        step();
        resp_ready8 = 1'b0;
        tests_run++;
        if (req_ready8 !== 1'b1 || resp_data8 !== exp) begin
            tests_failed++;
            $display("FAIL %s_return_idle: ready=%b data=%h, required 1 %h",
                     name, req_ready8, resp_data8, exp);
        end
    endtask

    task automatic test_ops();
        do_op8(8'hCA, 8'h5C, 2'b00, 8'h48, "and");
        do_op8(8'hCA, 8'h5C, 2'b01, 8'hDE, "or");
        do_op8(8'hCA, 8'h5C, 2'b10, 8'h21, "nor");
        do_op8(8'hCA, 8'h5C, 2'b11, 8'h96, "xor");
    endtask

    task automatic test_zero();
        do_op8(8'hF0, 8'h0F, 2'b00, 8'h00, "zero_and");
        do_op8(8'hFF, 8'h00, 2'b10, 8'h00, "zero_nor");
    endtask

    task automatic test_backpressure();
        int lat;
        req_a8 = 8'hCA; req_b8 = 8'h5C; req_op8 = 2'b01; req_valid8 = 1'b1;
        step();
        req_valid8 = 1'b0;
        lat = 0;
        while (resp_valid8 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests_run++;
        if (resp_valid8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_done_timeout: resp_valid=%b, required 1", resp_valid8);
        end
        // New request held during backpressure must wait.
        req_a8 = 8'h3C; req_b8 = 8'hA5; req_op8 = 2'b11; req_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (resp_data8 !== 8'hDE || req_ready8 !== 1'b0 || resp_valid8 !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: data=%h ready=%b valid=%b, required DE 0 1",
                         i, resp_data8, req_ready8, resp_valid8);
            end
        end
        $display("[TB] backpressure held 5 cycles, data=%h", resp_data8);
        resp_ready8 = 1'b1;
        step();
        resp_ready8 = 1'b0;
        tests_run++;
        if (req_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_handshake_idle: ready=%b busy=%b, required 1 0", req_ready8, busy8);
        end
        step();
        req_valid8 = 1'b0;
        tests_run++;
        if (busy8 !== 1'b1 || lu_control8 !== 2'b11) begin
            tests_failed++;
            $display("FAIL bp_accept: busy=%b lu_control=%b, required 1 11", busy8, lu_control8);
        end
        lat = 0;
        while (resp_valid8 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != 8 || resp_data8 !== 8'h99) begin
            tests_failed++;
            $display("FAIL bp_second_result: lat=%0d data=%h, required 8 99", lat, resp_data8);
        end
        $display("[TB] backpressure follow-up 3c^a5 -> %h", resp_data8);
        resp_ready8 = 1'b1;
        step();
        resp_ready8 = 1'b0;
    endtask

    task automatic test_midop_change();
        int lat;
        req_a8 = 8'hCA; req_b8 = 8'h5C; req_op8 = 2'b11; req_valid8 = 1'b1;
        step();
        req_valid8 = 1'b0;
        step();
        req_a8 = 8'hFF; req_b8 = 8'h00; req_op8 = 2'b00;
        lat = 1;
        while (resp_valid8 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != 8 || resp_data8 !== 8'h96) begin
            tests_failed++;
            $display("FAIL midop_change: lat=%0d data=%h, required 8 96", lat, resp_data8);
        end
        $display("[TB] mid-op change ignored -> %h", resp_data8);
        resp_ready8 = 1'b1;
        step();
        resp_ready8 = 1'b0;
    endtask

    task automatic test_reset_midop();
        bit seen_valid;
        req_a8 = 8'hF0; req_b8 = 8'hFF; req_op8 = 2'b01; req_valid8 = 1'b1;
        step();
        req_valid8 = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (req_ready8 !== 1'b1 || resp_valid8 !== 1'b0 || busy8 !== 1'b0 ||
            lu_control8 !== 2'b00 || resp_zero8 !== 1'b1 || resp_data8 !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_midop: ready=%b valid=%b busy=%b ctl=%b zero=%b data=%h, required 1 0 0 00 1 00",
                     req_ready8, resp_valid8, busy8, lu_control8, resp_zero8, resp_data8);
        end
        seen_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (resp_valid8 === 1'b1) seen_valid = 1;
        end
        tests_run++;
        if (seen_valid) begin
            tests_failed++;
            $display("FAIL reset_midop_no_resp: resp_valid seen=1, required 0");
        end
        $display("[TB] reset mid-op aborted operation");
        do_op8(8'h0F, 8'h33, 2'b01, 8'h3F, "after_reset");
    endtask

    task automatic test_width32();
        int lat;
        req_a32 = 32'hDEADBEEF; req_b32 = 32'h0F0F0F0F; req_op32 = 2'b11; req_valid32 = 1'b1;
        step();
        req_valid32 = 1'b0;
        lat = 0;
        while (resp_valid32 !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
        tests_run++;
        if (lat != 32) begin
            tests_failed++;
            $display("FAIL w32_latency: got %0d edges, required 32", lat);
        end
        tests_run++;
        if (resp_data32 !== 32'hD1A2B1E0 || resp_zero32 !== 1'b0) begin
            tests_failed++;
            $display("FAIL w32_xor: data=%h zero=%b, required d1a2b1e0 0", resp_data32, resp_zero32);
        end
        $display("[TB] w32 deadbeef ^ 0f0f0f0f -> %h", resp_data32);
        resp_ready32 = 1'b1;
        step();
        resp_ready32 = 1'b0;
        tests_run++;
        if (req_ready32 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w32_return_idle: ready=%b, required 1", req_ready32);
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero();
        test_backpressure();
        test_midop_change();
        test_reset_midop();
        test_width32();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
